uart_lane_tx: RTL and testbench
===============================

Name: uart_lane_tx

Overview:
- Multi-lane UART serializer for the chiplet link.
- Accepts one 10-bit symbol per lane, or a per-frame comma override, with a start pulse.
- Emits each symbol as a fixed 12-bit-time frame on its lane: start bit, 10 symbol bits LSB first, stop bit.
- Sits in front of the link pads; its frames are consumed by the uart_rx lanes at the far end.

Parameters:
- PORTCOUNT, 5: number of lanes.
- CLKDIV_W, 10: width of the baud counter.
- CLKDIV_COUNT, 10: CLK cycles per bit time. Legal range 2..2^CLKDIV_W-1; elaboration assertion otherwise.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset: one clock, synchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- comma_sel  in  2  0 = send data; 1 = K28.5 (10'b0011111010); 2 = K28.1 (10'b0011111001); 3 = K28.7 (10'b0011111000), same comma on all lanes.
- data  in  PORTCOUNT*10  lane i symbol = data[10*i+9:10*i].
- busy  out  1  high while a frame is in flight.
- done  out  1  one-cycle pulse at frame completion.
- tx_err  out  1  one-cycle pulse when start is rejected.
- uart_out  out  PORTCOUNT  serial lines, idle high.

Behaviour:
- Reset (RST high at a CLK edge): FSM=IDLE, baud counter=0, bit index=0, uart_out all 1s, busy=0, done=0, tx_err=0. Reset mid-frame aborts the frame: the line returns high on the next cycle and no done pulse is issued.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - start=1 latches data and comma_sel into the shift registers; the comma overrides every lane when comma_sel!=0.
  - Next state is START; busy=1 from the next cycle.
  - Later changes to data or comma_sel have no effect on the frame in flight.
- Baud counter: counts 0..CLKDIV_COUNT-1 in every non-IDLE state. The bit tick is the cycle where count==CLKDIV_COUNT-1; the counter wraps to 0 on the tick.
- START: uart_out=0 on all lanes for CLKDIV_COUNT cycles. On the tick, go to DATA with bit index 0.
- DATA:
  - uart_out[i] = symbol_i[bit index].
  - On each tick, bit index increments. On the tick with bit index 9, go to STOP.
- STOP: uart_out=1 for CLKDIV_COUNT cycles. On the tick, go to IDLE and assert done=1 for exactly the following cycle, the first cycle back in IDLE.
- Latency: first start bit appears the cycle after start is accepted. Each frame occupies 12*CLKDIV_COUNT cycles of busy.
- Back-to-back frames: start high in the cycle done is high is accepted. The next start bit begins the following cycle, so there is no idle gap beyond that one cycle.
- start while busy=1:
  - Request is dropped.
  - tx_err pulses the next cycle.
  - The current frame is unaffected.
  - A held-high start pulses tx_err every cycle while busy.
- All lanes share one FSM and counter, so lanes are bit-aligned.
- All outputs are registered.

Decomposition:
- Package uart_pkg holds:
  - state enum uart_tx_state_t;
  - comma constants COMMA_K28_5, COMMA_K28_1, COMMA_K28_7;
  - comma_sel encoding enum;
  - FRAME_BITS=12 and SYMBOL_BITS=10.
- Sub-module uart_baud_gen: parameterized CLKDIV_W/CLKDIV_COUNT counter with enable, clear and one-cycle tick output. uart_rx reuses it.
- The top module holds the FSM, the per-lane shift registers and the comma mux.

Test Plan (CLKDIV_COUNT=10, PORTCOUNT=5):
- Reset held for 3 cycles -> uart_out=5'b11111, busy=0, done=0, tx_err=0. After release with no start, the outputs stay at those values.
- start with data={10'b1101010100,10'b1010101011,10'b1111000011,10'b0000111100,10'b1100110011}, comma_sel=0:
  - Each lane shows 0 for 10 cycles, then its symbol LSB first at 10 cycles per bit, then 1 for 10 cycles.
  - done pulses exactly 120 cycles after the accept cycle.
  - A uart_rx loopback recovers the same 50-bit word.
- comma_sel=1 with arbitrary data -> all 5 lanes serialize 10'b0011111010. Repeat with comma_sel=2 and comma_sel=3 for their comma values.
- start raised again at cycle 50 of a frame -> tx_err high for 1 cycle, frame bits unchanged, exactly one done.
- Back-to-back: start asserted in the done cycle with data {10'b0101010101,...} -> second start bit begins the next cycle, and both frames decode correctly.
- RST asserted at cycle 60 of a frame -> uart_out=1s and busy=0 the next cycle, no done. A new start afterwards produces a clean frame.

Source files
------------

// File: rtl/uart_lane_tx_pkg.sv
// Shared definitions for the chiplet-link UART lanes (transmitter and receiver).
// Holds the FSM state type, the comma symbols, the comma_sel encoding and the
// frame geometry. No ports; imported with import uart_pkg::*.
package uart_pkg;

    localparam int FRAME_BITS  = 12;  // start + 10 symbol bits + stop
    localparam int SYMBOL_BITS = 10;

    localparam logic [SYMBOL_BITS-1:0] COMMA_K28_5 = 10'b0011111010;
    localparam logic [SYMBOL_BITS-1:0] COMMA_K28_1 = 10'b0011111001;
    localparam logic [SYMBOL_BITS-1:0] COMMA_K28_7 = 10'b0011111000;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        CSEL_DATA  = 2'd0,
        CSEL_K28_5 = 2'd1,
        CSEL_K28_1 = 2'd2,
        CSEL_K28_7 = 2'd3
    } comma_sel_t;

    // Comma symbol for a non-data selection; CSEL_DATA returns zero and is
    // never used as a symbol by callers.
    function automatic logic [SYMBOL_BITS-1:0] comma_value(input comma_sel_t sel);
        logic [SYMBOL_BITS-1:0] v;
        v = '0;
        case (sel)
            CSEL_K28_5: v = COMMA_K28_5;
            CSEL_K28_1: v = COMMA_K28_1;
            CSEL_K28_7: v = COMMA_K28_7;
            default:    v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/uart_lane_tx_if.sv
// Request/status bundle of the multi-lane UART transmitter.
//   start      frame request, sampled only while idle
//   comma_sel  0 = send data, 1/2/3 = K28.5/K28.1/K28.7 on every lane
//   data       lane i symbol at data[10*i +: 10]
//   busy       frame in flight
//   done       one-cycle pulse, first idle cycle after a frame
//   tx_err     one-cycle pulse after a start that arrived while busy
//   uart_out   serial lines, idle high
//   state_dbg  current transmitter FSM state
// Handshake: a request is taken on a clock edge where start=1 and busy=0
// (the done cycle counts as idle); a start seen while busy=1 is dropped and
// answered with tx_err on the following cycle.
interface uart_lane_tx_if #(
    parameter int PORTCOUNT = 5
);
    import uart_pkg::*;

    logic                             start;
    logic [1:0]                       comma_sel;
    logic [PORTCOUNT*SYMBOL_BITS-1:0] data;
    logic                             busy;
    logic                             done;
    logic                             tx_err;
    logic [PORTCOUNT-1:0]             uart_out;
    uart_tx_state_t                   state_dbg;

    modport master (
        output start, comma_sel, data,
        input  busy, done, tx_err, uart_out, state_dbg
    );

    modport slave (
        input  start, comma_sel, data,
        output busy, done, tx_err, uart_out, state_dbg
    );

endinterface

// File: rtl/uart_lane_tx_baud_gen.sv
// Bit-time generator shared by the UART transmitter and receiver.
//   clk, rst  clock and synchronous active-high reset
//   en        count while high
//   clr       force the count back to 0 (has priority over en)
//   tick      high in the cycle the count sits at CLKDIV_COUNT-1 while enabled;
//             the count wraps to 0 on that cycle's edge
module uart_baud_gen #(
    parameter int CLKDIV_W     = 10,
    parameter int CLKDIV_COUNT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    if (CLKDIV_COUNT < 2 || CLKDIV_COUNT > (1 << CLKDIV_W) - 1) begin : g_bad_div
        $error("uart_baud_gen: CLKDIV_COUNT out of range 2..2^CLKDIV_W-1");
    end

    localparam logic [CLKDIV_W-1:0] LAST = CLKDIV_W'(CLKDIV_COUNT - 1);

    logic [CLKDIV_W-1:0] count_q, count_d;

    assign tick = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CLKDIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_lane_tx.sv
// Multi-lane UART serializer. One shared FSM and baud counter drive
// PORTCOUNT bit-aligned lanes; each frame is start(0), 10 symbol bits LSB
// first, stop(1), each bit CLKDIV_COUNT cycles long.
//   CLK, RST  clock and synchronous active-high reset
//   bus       uart_lane_tx_if.slave (start/comma_sel/data in,
//             busy/done/tx_err/uart_out/state_dbg out)
// All outputs are registered: the *_d values are computed from the next
// state so each output lines up with the state it describes.
module uart_lane_tx
    import uart_pkg::*;
#(
    parameter int PORTCOUNT    = 5,
    parameter int CLKDIV_W     = 10,
    parameter int CLKDIV_COUNT = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_lane_tx_if.slave         bus
);

    localparam int IDX_W = $clog2(SYMBOL_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(SYMBOL_BITS - 1);
    localparam int LW = PORTCOUNT * SYMBOL_BITS;

    uart_tx_state_t       state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [LW-1:0]        shift_q, shift_d;
    logic [PORTCOUNT-1:0] uart_out_q, uart_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tx_err_q, tx_err_d;
    logic                 tick;
    logic                 in_frame;

    assign in_frame = (state_q != TX_IDLE);

    uart_baud_gen #(
        .CLKDIV_W     (CLKDIV_W),
        .CLKDIV_COUNT (CLKDIV_COUNT)
    ) u_baud (
        .clk  (CLK),
        .rst  (RST),
        .en   (in_frame),
        .clr  (!in_frame),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        tx_err_d   = bus.start && in_frame;
        uart_out_d = '1;

        case (state_q)
            TX_IDLE: begin
                if (bus.start) begin
                    state_d   = TX_START;
                    bit_idx_d = '0;
                    for (int i = 0; i < PORTCOUNT; i++) begin
                        if (bus.comma_sel != 2'd0) begin
                            shift_d[i*SYMBOL_BITS +: SYMBOL_BITS] =
                                comma_value(comma_sel_t'(bus.comma_sel));
                        end else begin
                            shift_d[i*SYMBOL_BITS +: SYMBOL_BITS] =
                                bus.data[i*SYMBOL_BITS +: SYMBOL_BITS];
                        end
                    end
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d   = TX_DATA;
                    bit_idx_d = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        // Bit 0 of each lane slice is always the bit on the wire.
                        for (int i = 0; i < PORTCOUNT; i++) begin
                            shift_d[i*SYMBOL_BITS +: SYMBOL_BITS] =
                                {1'b0, shift_q[i*SYMBOL_BITS+1 +: SYMBOL_BITS-1]};
                        end
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        busy_d = (state_d != TX_IDLE);
        for (int i = 0; i < PORTCOUNT; i++) begin
            case (state_d)
                TX_START: uart_out_d[i] = 1'b0;
                TX_DATA:  uart_out_d[i] = shift_d[i*SYMBOL_BITS];
                default:  uart_out_d[i] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= TX_IDLE;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_out_q <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            uart_out_q <= uart_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.tx_err    = tx_err_q;
    assign bus.uart_out  = uart_out_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_lane_tx.sv
module tb_uart_lane_tx;
    import uart_pkg::*;

    localparam int PC = 5;
    localparam int CD = 10;
    localparam int W  = PC * 10;

    localparam logic [W-1:0] D1 = {10'b1101010100, 10'b1010101011, 10'b1111000011,
                                   10'b0000111100, 10'b1100110011};
    localparam logic [W-1:0] D2 = {10'b0101010101, 10'b1010101010, 10'b0011001100,
                                   10'b1110001110, 10'b0000011111};
    localparam logic [W-1:0] K5 = {5{10'b0011111010}};
    localparam logic [W-1:0] K1 = {5{10'b0011111001}};
    localparam logic [W-1:0] K7 = {5{10'b0011111000}};

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    uart_lane_tx_if #(.PORTCOUNT(PC)) u_if ();

    uart_lane_tx #(
        .PORTCOUNT    (PC),
        .CLKDIV_W     (10),
        .CLKDIV_COUNT (CD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described by its age: the number of clock edges since the
    // accepting edge. Ages 1..10 start bit, 11..110 symbol bits, 111..120
    // stop bit, 121 the done cycle (idle, new requests accepted).
    logic [W-1:0] exp_q[$];
    bit           m_active = 0;
    int           m_age    = 0;
    logic [W-1:0] m_sym    = '0;
    bit           m_txerr  = 0;
    bit           cmp_en   = 0;

    function automatic logic [9:0] comma_of(input logic [1:0] cs);
        case (cs)
            2'd1:    return 10'b0011111010;
            2'd2:    return 10'b0011111001;
            default: return 10'b0011111000;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            // frame cut off before the receiver finished it: never arrives
            if (m_active && m_age <= 115 && exp_q.size() > 0) void'(exp_q.pop_back());
            m_active = 0;
            m_age    = 0;
            m_txerr  = 0;
            cmp_en   = 1;
        end else begin
            bit in_flight;
            in_flight = m_active && m_age >= 1 && m_age <= 120;
            m_txerr = u_if.start && in_flight;
            if (u_if.start && !in_flight) begin
                for (int i = 0; i < PC; i++)
                    m_sym[10*i +: 10] = (u_if.comma_sel != 2'd0) ? comma_of(u_if.comma_sel)
                                                                 : u_if.data[10*i +: 10];
                m_active = 1;
                m_age    = 1;
                exp_q.push_back(m_sym);
            end else if (m_active) begin
                m_age++;
                if (m_age > 121) m_active = 0;
            end
        end
    end

    function automatic logic [PC-1:0] exp_line();
        logic [PC-1:0] v;
        v = '1;
        if (m_active && m_age >= 1 && m_age <= 10) v = '0;
        else if (m_active && m_age >= 11 && m_age <= 110)
            for (int i = 0; i < PC; i++) v[i] = m_sym[10*i + (m_age - 11) / 10];
        return v;
    endfunction

    // per-cycle compare
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("uart_out", 64'(u_if.uart_out), 64'(exp_line()));
            check("busy",     64'(u_if.busy),     64'(m_active && m_age >= 1 && m_age <= 120));
            check("done",     64'(u_if.done),     64'(m_active && m_age == 121));
            check("tx_err",   64'(u_if.tx_err),   64'(m_txerr));
        end
    end

    // ---------------- loopback receiver / scoreboard ----------------
    bit           rx_busy = 0;
    int           rx_t = 0;
    int           rx_frames = 0;
    logic [W-1:0] rx_word = '0;
    logic [W-1:0] last_rx = '0;

    always @(negedge CLK) begin
        if (!rx_busy) begin
            if (u_if.uart_out === '0) begin
                rx_busy = 1;
                rx_t    = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == 5) check("rx_start_bit", 64'(u_if.uart_out), 64'(0));
            if (rx_t >= 15 && rx_t <= 105 && (rx_t - 15) % 10 == 0)
                for (int i = 0; i < PC; i++) rx_word[10*i + (rx_t - 15) / 10] = u_if.uart_out[i];
            if (rx_t == 115) begin
                rx_busy = 0;
                check("rx_stop_bit", 64'(u_if.uart_out), 64'({PC{1'b1}}));
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected_frame got=%0h exp=none", rx_word);
                end else begin
                    check("rx_word", 64'(rx_word), 64'(exp_q.pop_front()));
                end
                last_rx = rx_word;
                rx_frames++;
            end
        end
        if (RST) rx_busy = 0;
    end

    // pulse counters and busy-run length
    int busy_run = 0, last_busy_run = 0, done_cnt = 0, err_cnt = 0;
    always @(negedge CLK) begin
        if (u_if.tx_err === 1'b1) err_cnt++;
        if (u_if.busy === 1'b1) busy_run++;
        else begin
            if (u_if.done === 1'b1) begin
                done_cnt++;
                last_busy_run = busy_run;
            end
            busy_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] cs);
        u_if.start     = 1'b1;
        u_if.data      = d;
        u_if.comma_sel = cs;
        tick(1);
        acc_cyc        = cyc;
        u_if.start     = 1'b0;
        u_if.data      = W'({$urandom(), $urandom()});
        u_if.comma_sel = 2'($urandom_range(0, 3));
    endtask

    // Returns in the done cycle (sampled 1 time unit after its edge).
    task automatic wait_done(output int done_at);
        done_at = -1;
        for (int i = 0; i < 400; i++) begin
            if (u_if.done === 1'b1) begin
                done_at = cyc;
                return;
            end
            tick(1);
        end
        checks++;
        failures++;
        $display("FAIL wait_done_timeout got=no_done exp=done cyc=%0d", cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t_done;
        int d0, e0, f0;
        u_if.start     = 1'b0;
        u_if.data      = '0;
        u_if.comma_sel = 2'd0;
        RST = 1'b1;
        tick(3);
        check("reset_uart_out", 64'(u_if.uart_out), 64'(5'b11111));
        check("reset_busy",     64'(u_if.busy),     64'(0));
        check("reset_done",     64'(u_if.done),     64'(0));
        check("reset_tx_err",   64'(u_if.tx_err),   64'(0));
        RST = 1'b0;
        tick(6);
        check("idle_uart_out", 64'(u_if.uart_out), 64'(5'b11111));
        check("idle_busy",     64'(u_if.busy),     64'(0));

        // data frame: timing and content
        send(D1, 2'd0);
        check("first_start_bit", 64'(u_if.uart_out), 64'(0));
        wait_done(t_done);
        check("done_latency", 64'(t_done - acc_cyc), 64'(120));
        tick(1);
        check("busy_length", 64'(last_busy_run), 64'(120));
        check("d1_loopback", 64'(last_rx), 64'(D1));
        tick(3);

        // comma overrides
        send(W'({$urandom(), $urandom()}), 2'd1);
        wait_done(t_done);
        tick(1);
        check("k28_5", 64'(last_rx), 64'(K5));
        send(W'({$urandom(), $urandom()}), 2'd2);
        wait_done(t_done);
        tick(1);
        check("k28_1", 64'(last_rx), 64'(K1));
        send(W'({$urandom(), $urandom()}), 2'd3);
        wait_done(t_done);
        tick(1);
        check("k28_7", 64'(last_rx), 64'(K7));
        tick(2);

        // start while busy
        e0 = err_cnt;
        d0 = done_cnt;
        send(D2, 2'd0);
        tick(49);
        u_if.start = 1'b1;
        u_if.data  = D1;
        tick(1);
        u_if.start = 1'b0;
        wait_done(t_done);
        tick(1);
        check("busy_start_tx_err", 64'(err_cnt - e0), 64'(1));
        check("busy_start_done",   64'(done_cnt - d0), 64'(1));
        check("busy_start_frame",  64'(last_rx), 64'(D2));
        tick(2);

        // back-to-back
        f0 = rx_frames;
        send(D1, 2'd0);
        wait_done(t_done);
        send(D2, 2'd0);
        check("b2b_start_bit", 64'(u_if.uart_out), 64'(0));
        check("b2b_busy",      64'(u_if.busy),     64'(1));
        wait_done(t_done);
        tick(1);
        check("b2b_second", 64'(last_rx), 64'(D2));
        check("b2b_frames", 64'(rx_frames - f0), 64'(2));
        tick(2);

        // reset mid-frame
        d0 = done_cnt;
        send(D1, 2'd0);
        tick(59);
        RST = 1'b1;
        tick(1);
        check("abort_uart_out", 64'(u_if.uart_out), 64'(5'b11111));
        check("abort_busy",     64'(u_if.busy),     64'(0));
        RST = 1'b0;
        tick(130);
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        send(D2, 2'd0);
        wait_done(t_done);
        tick(1);
        check("after_abort", 64'(last_rx), 64'(D2));
        tick(2);

        // randomized frames
        for (int n = 0; n < 30; n++) begin
            int r;
            logic [1:0] cs;
            cs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            send(W'({$urandom(), $urandom()}), cs);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                tick($urandom_range(1, 118));
                RST = 1'b1;
                tick($urandom_range(1, 2));
                RST = 1'b0;
                tick($urandom_range(1, 4));
            end else begin
                if (r < 4) begin
                    tick($urandom_range(1, 100));
                    u_if.start = 1'b1;
                    tick($urandom_range(1, 3));
                    u_if.start = 1'b0;
                end
                wait_done(t_done);
                if (r < 6) tick($urandom_range(1, 5));
            end
        end

        tick(200);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
